// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the writable instruction memory.
//   state_e     : loader FSM states
//   NOP_WORD    : value written to every word while clearing
//   COUNT_BYTES : number of big-endian bytes carrying the word count
package imem_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        CSUM,
        DONE
    } state_e;

    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
    localparam int          COUNT_BYTES = 2;

endpackage

// File: rtl/imem_word_pack.sv
// imem_word_pack: assembles big-endian 32-bit words from a byte stream.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear_i         drop any partially assembled word
//   byte_valid_i    byte_i is accepted this cycle
//   byte_i          stream byte
//   word_o          assembled word (valid together with word_valid_o)
//   word_valid_o    one-cycle strobe in the cycle the 4th byte is accepted
module imem_word_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sh_q, sh_d;

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (byte_valid_i) begin
            cnt_d = cnt_q + 2'd1;
            sh_d  = {sh_q[15:0], byte_i};
        end
    end

    // The 4th byte is combined directly so the word can be written on the
    // same edge that accepts it.
    assign word_o       = {sh_q, byte_i};
    assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: register-array instruction memory with a byte-stream loader.
// The CPU reads combinationally; a loader FSM clears memory after reset and
// fills it from a stream of: 16-bit big-endian word count N, then N words.
// Optional macro IMEM_CHECKSUM_EN: a trailing XOR checksum byte is checked;
// on mismatch memory is wiped and load_err is set.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   fetch_addr / fetch_data         CPU byte address / instruction word
//   fetch_oob                       word index beyond DEPTH (data reads 0)
//   load_start                      begin a load (honoured only when idle)
//   load_byte/load_valid/load_ready byte stream handshake
//   cpu_hold                        CPU stall while clearing/loading
//   cpu_restart                     one-cycle PC-to-0 request after a load
//   load_done/load_overflow/load_err sticky status flags
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_addr,
    output logic [31:0] fetch_data,
    output logic        fetch_oob,
    input  logic        load_start,
    input  logic [7:0]  load_byte,
    input  logic        load_valid,
    output logic        load_ready,
    output logic        cpu_hold,
    output logic        cpu_restart,
    output logic        load_done,
    output logic        load_overflow,
    output logic        load_err
);

    localparam int CNT_W = 8 * COUNT_BYTES;

`ifdef IMEM_CHECKSUM_EN
    localparam state_e AFTER_DATA = CSUM;
`else
    localparam state_e AFTER_DATA = DONE;
`endif

    state_e             state_q, state_d;
    logic [AW-1:0]      clr_ptr_q, clr_ptr_d;
    logic [16:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic [31:0]        mem_q [DEPTH];
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [31:0]        mem_wdata;

    logic               accept;
    logic [31:0]        word;
    logic               word_valid;
    logic               last_word;
    logic [CNT_W-1:0]   cnt_full;

    assign accept    = load_valid && load_ready;
    assign cnt_full  = {cnt_q[CNT_W-1:8], load_byte};
    assign last_word = word_valid && ((wr_ptr_q + 17'd1) == {1'b0, cnt_q});

    imem_word_pack u_pack (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (state_q != DATA),
        .byte_valid_i (accept && (state_q == DATA)),
        .byte_i       (load_byte),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

`ifdef IMEM_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       err_q, err_d;
    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:  if (clr_ptr_q == AW'(DEPTH - 1)) state_d = IDLE;
            IDLE:   if (load_start) state_d = CNT_HI;
            CNT_HI: if (accept) state_d = CNT_LO;
            CNT_LO: if (accept) state_d = (cnt_full == '0) ? AFTER_DATA : DATA;
            DATA:   if (last_word) state_d = AFTER_DATA;
`ifdef IMEM_CHECKSUM_EN
            CSUM:   if (accept) state_d = (load_byte == csum_q) ? DONE : CLEAR;
`endif
            DONE:   state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    // FSM outputs
    always_comb begin
        cpu_hold    = (state_q != IDLE);
        cpu_restart = (state_q == DONE);
        load_ready  = (state_q == CNT_HI) || (state_q == CNT_LO) ||
                      (state_q == DATA)   || (state_q == CSUM);
    end

    // Pointers, count, flags and memory write port
    always_comb begin
        clr_ptr_d = clr_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_waddr = clr_ptr_q;
        mem_wdata = NOP_WORD;
`ifdef IMEM_CHECKSUM_EN
        csum_d    = csum_q;
        err_d     = err_q;
`endif
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                // DEPTH is a power of two, so this wraps back to 0.
                clr_ptr_d = clr_ptr_q + AW'(1);
            end
            IDLE: begin
                if (load_start) begin
                    done_d   = 1'b0;
                    ovf_d    = 1'b0;
                    wr_ptr_d = 17'd0;
`ifdef IMEM_CHECKSUM_EN
                    err_d    = 1'b0;
                    csum_d   = 8'h00;
`endif
                end
            end
            CNT_HI: if (accept) cnt_d[CNT_W-1:8] = load_byte;
            CNT_LO: if (accept) cnt_d = cnt_full;
            DATA: begin
                if (word_valid) begin
                    wr_ptr_d = wr_ptr_q + 17'd1;
                    if (wr_ptr_q >= 17'(DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = wr_ptr_q[AW-1:0];
                        mem_wdata = word;
                    end
                end
            end
`ifdef IMEM_CHECKSUM_EN
            CSUM: begin
                if (accept && (load_byte != csum_q)) begin
                    err_d     = 1'b1;
                    clr_ptr_d = '0;
                end
            end
`endif
            default: ;
        endcase
`ifdef IMEM_CHECKSUM_EN
        if (accept && (state_q != CSUM)) csum_d = csum_q ^ load_byte;
`endif
        if (state_d == DONE) done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr_q <= '0;
            wr_ptr_q  <= 17'd0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            csum_q    <= 8'h00;
            err_q     <= 1'b0;
`endif
        end else begin
            clr_ptr_q <= clr_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
`ifdef IMEM_CHECKSUM_EN
            csum_q    <= csum_d;
            err_q     <= err_d;
`endif
        end
    end

    // Memory contents are established by the CLEAR pass, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign load_done     = done_q;
    assign load_overflow = ovf_q;

    // Bit 31 (supervisor) and the byte offset do not select a word.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_addr[31], fetch_addr[1:0]};

    assign fetch_oob  = (fetch_addr[30:2] >= 29'(DEPTH));
    assign fetch_data = fetch_oob ? NOP_WORD : mem_q[fetch_addr[AW+1:2]];

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        fetch_oob;
    logic        load_start;
    logic [7:0]  load_byte;
    logic        load_valid;
    logic        load_ready;
    logic        cpu_hold;
    logic        cpu_restart;
    logic        load_done;
    logic        load_overflow;
    logic        load_err;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_addr    (fetch_addr),
        .fetch_data    (fetch_data),
        .fetch_oob     (fetch_oob),
        .load_start    (load_start),
        .load_byte     (load_byte),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .cpu_hold      (cpu_hold),
        .cpu_restart   (cpu_restart),
        .load_done     (load_done),
        .load_overflow (load_overflow),
        .load_err      (load_err)
    );

    int tests = 0;
    int fails = 0;

    // Counts cycles in which cpu_restart is high.
    int restart_cnt = 0;
    always @(negedge clk) if (rst_n && cpu_restart) restart_cnt++;

    // Reference model: expected memory image and expected overflow flag.
    logic [31:0] model_mem [DEPTH];
    bit          model_ovf;
    logic [31:0] words_q [$];
    logic [7:0]  stream_q [$];

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    task automatic model_load(input int n);
        for (int i = 0; i < n && i < DEPTH; i++) model_mem[i] = words_q[i];
        model_ovf = (n > DEPTH);
    endtask

    task automatic gen_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    task automatic build_stream(input int n);
        logic [31:0] w;
        stream_q.delete();
        stream_q.push_back(8'(n >> 8));
        stream_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = words_q[i];
            stream_q.push_back(w[31:24]);
            stream_q.push_back(w[23:16]);
            stream_q.push_back(w[15:8]);
            stream_q.push_back(w[7:0]);
        end
`ifdef IMEM_CHECKSUM_EN
        begin
            logic [7:0] cs;
            cs = 8'h00;
            foreach (stream_q[i]) cs ^= stream_q[i];
            stream_q.push_back(cs);
        end
`endif
    endtask

    task automatic do_start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    // Sends stream_q[0 .. stop_at-1]; optionally pulses load_start with byte start_at.
    task automatic send_stream(input int gap_pct, input int start_at, input int stop_at);
        logic r;
        int   cyc;
        for (int i = 0; i < stop_at; i++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
                load_valid = 1'b0;
                @(posedge clk); #1;
            end
            load_valid = 1'b1;
            load_byte  = stream_q[i];
            load_start = (i == start_at);
            cyc = 0;
            do begin
                @(negedge clk) r = load_ready;
                @(posedge clk); #1;
                load_start = 1'b0;
                cyc++;
            end while (!r && cyc < 50);
            if (!r) begin
                tests++; fails++;
                $display("FAIL stream_stall: byte %0d not accepted, load_ready=%b required 1", i, r);
                load_valid = 1'b0;
                return;
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int cyc = 0;
        while (cpu_hold && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (cpu_hold !== 1'b0) begin
            fails++;
            $display("FAIL %s: cpu_hold=%b after %0d cycles, required 0", name, cpu_hold, budget);
        end
    endtask

    task automatic check_mem(input string name);
        logic b31;
        logic [1:0] off;
        for (int i = 0; i < DEPTH; i++) begin
            b31 = 1'($urandom_range(1));
            off = 2'($urandom_range(3));
            fetch_addr = {b31, 29'(i), off};
            #1;
            tests++;
            if (fetch_data !== model_mem[i] || fetch_oob !== 1'b0) begin
                fails++;
                $display("FAIL %s: word %0d data=%h oob=%b, required %h oob=0",
                         name, i, fetch_data, fetch_oob, model_mem[i]);
            end
        end
    endtask

    // Runs a well-formed load of words_q[0..n-1] and checks handshake, timing and flags.
    task automatic run_load(input string name, input int n, input int gap_pct, input int start_at);
        int r0;
        build_stream(n);
        r0 = restart_cnt;
        do_start();
        tests++;
        if (load_ready !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0 || load_overflow !== 1'b0) begin
            fails++;
            $display("FAIL %s_start: ready=%b hold=%b done=%b ovf=%b, required 1 1 0 0",
                     name, load_ready, cpu_hold, load_done, load_overflow);
        end
        if (n >= 1 && n <= DEPTH) fetch_addr = {1'b0, 29'(n - 1), 2'b00};
        send_stream(gap_pct, start_at, stream_q.size());
        tests++;
        if (cpu_restart !== 1'b1 || load_done !== 1'b1) begin
            fails++;
            $display("FAIL %s_done_pulse: restart=%b done=%b, required 1 1", name, cpu_restart, load_done);
        end
        if (n >= 1 && n <= DEPTH) begin
            tests++;
            if (fetch_data !== words_q[n - 1]) begin
                fails++;
                $display("FAIL %s_last_word: data=%h required %h", name, fetch_data, words_q[n - 1]);
            end
        end
        @(posedge clk); #1;
        model_load(n);
        tests++;
        if (cpu_hold !== 1'b0 || cpu_restart !== 1'b0 || (restart_cnt - r0) != 1 ||
            load_done !== 1'b1 || load_overflow !== model_ovf || load_err !== 1'b0) begin
            fails++;
            $display("FAIL %s_end: hold=%b restart=%b pulses=%0d done=%b ovf=%b err=%b, required 0 0 1 1 %b 0",
                     name, cpu_hold, cpu_restart, restart_cnt - r0, load_done, load_overflow, load_err, model_ovf);
        end
        check_mem(name);
    endtask

    task automatic release_and_clear(input string name);
        int cnt = 0;
        @(negedge clk) rst_n = 1'b1;
        #1;
        while (cpu_hold && cnt < 200) begin
            cnt++;
            @(posedge clk); #1;
        end
        tests++;
        if (cnt != DEPTH) begin
            fails++;
            $display("FAIL %s_clear_len: cpu_hold high for %0d cycles, required %0d", name, cnt, DEPTH);
        end
        model_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h00; fetch_addr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (cpu_hold !== 1'b1 || cpu_restart !== 1'b0 || load_ready !== 1'b0 ||
            load_done !== 1'b0 || load_overflow !== 1'b0 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: hold=%b restart=%b ready=%b done=%b ovf=%b err=%b, required 1 0 0 0 0 0",
                     cpu_hold, cpu_restart, load_ready, load_done, load_overflow, load_err);
        end
        release_and_clear("reset");
        tests++;
        if (load_ready !== 1'b0 || load_done !== 1'b0 || load_overflow !== 1'b0 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_flags: ready=%b done=%b ovf=%b err=%b, required 0 0 0 0",
                     load_ready, load_done, load_overflow, load_err);
        end
        check_mem("reset_mem");
    endtask

    task automatic set_scenario_words();
        words_q.delete();
        words_q.push_back(32'h0800_0003);
        words_q.push_back(32'h3C04_4000);
        words_q.push_back(32'h2010_00F9);
    endtask

    task automatic test_load_basic();
        set_scenario_words();
        run_load("basic", 3, 0, -1);
    endtask

    task automatic test_fetch_alias();
        fetch_addr = 32'h8000_0004; #1;
        tests++;
        if (fetch_data !== 32'h3C04_4000 || fetch_oob !== 1'b0) begin
            fails++;
            $display("FAIL alias_b31: data=%h oob=%b, required 3c044000 0", fetch_data, fetch_oob);
        end
        fetch_addr = 32'h0000_0100; #1;
        tests++;
        if (fetch_data !== 32'h0 || fetch_oob !== 1'b1) begin
            fails++;
            $display("FAIL oob_0x100: data=%h oob=%b, required 0 1", fetch_data, fetch_oob);
        end
        fetch_addr = 32'h0000_00FC; #1;
        tests++;
        if (fetch_oob !== 1'b0) begin
            fails++;
            $display("FAIL inrange_0xfc: oob=%b required 0", fetch_oob);
        end
        for (int i = 0; i < 8; i++) begin
            logic [28:0] idx;
            idx = 29'(DEPTH) + 29'($urandom_range(100000));
            if (i == 0) idx = 29'h1FFF_FFFF;
            fetch_addr = {1'($urandom_range(1)), idx, 2'($urandom_range(3))};
            #1;
            tests++;
            if (fetch_data !== 32'h0 || fetch_oob !== 1'b1) begin
                fails++;
                $display("FAIL oob_rand: addr=%h data=%h oob=%b, required 0 1", fetch_addr, fetch_data, fetch_oob);
            end
        end
    endtask

    task automatic test_overflow();
        gen_words(DEPTH + 2);
        run_load("overflow", DEPTH + 2, 10, -1);
    endtask

    task automatic test_gaps_and_start();
        set_scenario_words();
        run_load("gaps_start", 3, 40, 6);
    endtask

    task automatic test_random_loads();
        for (int k = 0; k < 4; k++) begin
            int n;
            n = (k == 0) ? 0 : $urandom_range(1, DEPTH + 6);
            gen_words(n);
            run_load("random", n, $urandom_range(50), -1);
        end
    endtask

    task automatic test_reset_midload();
        gen_words(10);
        build_stream(10);
        do_start();
        send_stream(0, -1, 15);
        rst_n = 1'b0;
        #1;
        tests++;
        if (cpu_hold !== 1'b1 || load_ready !== 1'b0 || load_done !== 1'b0 ||
            load_overflow !== 1'b0 || load_err !== 1'b0 || cpu_restart !== 1'b0) begin
            fails++;
            $display("FAIL midload_reset: hold=%b ready=%b done=%b ovf=%b err=%b restart=%b, required 1 0 0 0 0 0",
                     cpu_hold, load_ready, load_done, load_overflow, load_err, cpu_restart);
        end
        @(posedge clk); #1;
        release_and_clear("midload");
        check_mem("midload_mem");
        model_ovf = 1'b0;
    endtask

`ifdef IMEM_CHECKSUM_EN
    task automatic test_checksum();
        int r0;
        set_scenario_words();
        run_load("csum_good", 3, 20, -1);
        build_stream(3);
        stream_q[stream_q.size() - 1] = stream_q[stream_q.size() - 1] ^ 8'h5A;
        r0 = restart_cnt;
        do_start();
        send_stream(20, -1, stream_q.size());
        wait_idle("csum_bad_clear", 200);
        model_clear();
        tests++;
        if (load_err !== 1'b1 || load_done !== 1'b0 || (restart_cnt - r0) != 0) begin
            fails++;
            $display("FAIL csum_bad_flags: err=%b done=%b pulses=%0d, required 1 0 0",
                     load_err, load_done, restart_cnt - r0);
        end
        check_mem("csum_bad_mem");
        words_q.delete();
        run_load("csum_after_err", 0, 0, -1);
    endtask
`endif

    initial begin
        model_ovf = 1'b0;
        test_reset();
        test_load_basic();
        test_fetch_alias();
        test_overflow();
        test_gaps_and_start();
        test_random_loads();
        test_reset_midload();
`ifdef IMEM_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised, writable instruction memory for the MIPS core. It replaces the fixed ROM image with a register-array memory that the CPU fetches from combinationally, and that is filled at run time from a byte stream (UART receiver) by a loader state machine. While memory is being cleared or loaded, the block holds the CPU. When a load completes, it pulses a restart request so the CPU re-fetches from address 0.

## Interface
Parameters:
- DEPTH, 64: memory size in 32-bit words; power of two, 16..4096.
- AW, $clog2(DEPTH): word-index width; derived, do not override.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock domain; reset is asynchronous and active-low.
- fetch_addr  in  32  CPU byte address. Bit 31 (supervisor flag) and bits 1:0 are ignored.
- fetch_data  out  32  instruction word, combinational from fetch_addr.
- fetch_oob  out  1  asserted when fetch_addr[30:2] >= DEPTH.
- load_start  in  1  single-cycle request to begin a load.
- load_byte  in  8  stream byte.
- load_valid  in  1  load_byte is valid.
- load_ready  out  1  block accepts a byte this cycle.
- cpu_hold  out  1  CPU must stall.
- cpu_restart  out  1  one-cycle pulse; CPU resets its PC to 0.
- load_done  out  1  sticky; last load completed successfully.
- load_overflow  out  1  sticky; the word count exceeded DEPTH.
- load_err  out  1  sticky; checksum mismatch (tied to 0 without the macro).

## Operation
- A byte is accepted only when load_valid and load_ready are both 1.
- States:
  - CLEAR: writes 32'h0 (NOP) to word clr_ptr each cycle. After word DEPTH-1, go to IDLE.
  - IDLE: on load_start, clear load_done, load_overflow and load_err, then go to CNT_HI.
  - CNT_HI, CNT_LO: receive a 16-bit big-endian word count N. If N==0, go to DONE (or CSUM when the macro is enabled).
  - DATA: receives 4 bytes per word, big-endian (first byte is [31:24]).
    - When the 4th byte is accepted, write the word to index wr_ptr and increment wr_ptr.
    - If wr_ptr >= DEPTH, discard the word and set load_overflow.
    - After N words, go to DONE (or CSUM).
  - CSUM: macro only; see Configuration.
  - DONE: for one cycle, cpu_restart=1 and load_done=1; then go to IDLE.
- load_start outside IDLE is ignored.
- cpu_hold = (state != IDLE).
- load_ready = 1 in CNT_HI, CNT_LO, DATA and CSUM only.
- Fetch read:
  - fetch_data = mem[fetch_addr[AW+1:2]] when in range.
  - Out of range: fetch_data = 32'h0 and fetch_oob = 1.
  - The fetch port stays live in every state.
- Widths:
  - N is 16 bits.
  - wr_ptr is 17 bits, so overflow detection does not wrap.
  - The checksum is an 8-bit XOR.

## Timing
- Reset values:
  - state=CLEAR, clr_ptr=0, wr_ptr=0.
  - cpu_hold=1, cpu_restart=0, load_ready=0.
  - load_done=0, load_overflow=0, load_err=0.
- After rst_n deasserts, CLEAR lasts exactly DEPTH cycles; cpu_hold falls on the following cycle.
- load_start sampled in IDLE at edge k: cpu_hold=1 and load_ready=1 from cycle k+1.
- Word write takes effect at the edge that accepts its 4th byte; fetch_data reflects it in the same cycle after that edge.
- The DONE pulse is in the cycle after the final byte is accepted. cpu_hold drops one cycle after DONE.
- If rst_n is asserted mid-load, the load is aborted, memory is re-cleared, and the sticky flags are zeroed.
- A load_valid without load_ready is not consumed, and the bench must hold the byte. Gaps in load_valid are allowed anywhere.

## Configuration
- IMEM_CHECKSUM_EN defined:
  - After the data words, one extra byte is received in CSUM. It must equal the XOR of all preceding stream bytes, count bytes included.
  - Match: go to DONE.
  - Mismatch: set load_err, skip DONE (no cpu_restart), and go to CLEAR to wipe memory. cpu_hold stays 1 until the clear ends.
- Not defined: no CSUM state; DATA or count goes directly to DONE; load_err is constant 0.

## Structure
- Package imem_pkg holds:
  - the state enum (CLEAR, IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE);
  - NOP_WORD = 32'h0000_0000;
  - COUNT_BYTES = 2.
- Sub-module imem_word_pack: shifts in bytes, outputs a 32-bit word plus a one-cycle word_valid on the 4th byte, and has a clear input. The top block owns the FSM, pointers, memory and checksum.

## Test plan
1. Reset release, DEPTH=64 -> cpu_hold=1 for 64 cycles then 0; fetch 0x00..0xFC all return 0; all flags 0.
2. load_start; stream 00 03 08 00 00 03 3C 04 40 00 20 10 00 F9 -> fetch 0x0/0x4/0x8 = 0x08000003/0x3C044000/0x201000F9; cpu_restart is high for one cycle; load_done=1.
3. fetch_addr 0x80000004 -> same data as 0x4; fetch_addr 0x100 -> data 0, fetch_oob=1.
4. DEPTH=64, N=66 -> words 0..63 written, words 64..65 dropped; load_overflow=1; load completes with cpu_restart.
5. Random load_valid gaps plus load_start pulsed mid-DATA -> contents identical to scenario 2; the extra start is ignored.
6. IMEM_CHECKSUM_EN, scenario 2 with correct checksum -> load_done. Wrong checksum -> load_err=1, no cpu_restart, memory all 0 after 64 clear cycles.
